// File: rtl/tt_pkg.sv
// tt_pkg: FSM state encoding and golden truth tables for 2-input gates
package tt_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, APPLY = 2'd1, CHECK = 2'd2, DONE = 2'd3} state_t;
   localparam logic [3:0] TT_NAND2 = 4'b0111;
   localparam logic [3:0] TT_AND2  = 4'b1000;
   localparam logic [3:0] TT_OR2   = 4'b1110;
   localparam logic [3:0] TT_XOR2  = 4'b0110;
endpackage

// File: rtl/tt_compare.sv
// tt_compare: flags a gate output that differs from the golden bit, X/Z included
module tt_compare #(
   parameter int N_IN = 2
) (
   input  logic [N_IN-1:0]      i_m,
   input  logic [2**N_IN-1:0]   i_truth,
   input  logic                 i_dut_s,
   output logic                 o_mismatch
);
   assign o_mismatch = i_dut_s !== i_truth[i_m];
endmodule

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: sweeps every minterm into a gate and scores it against a golden truth table
module truth_table_sequencer
   import tt_pkg::*;
#(
   parameter int                N_IN  = 2,
   parameter logic [2**N_IN-1:0] TRUTH = TT_NAND2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 dut_s,
   output logic [N_IN-1:0]      x,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [N_IN:0]        err_count,
   output logic [2**N_IN-1:0]   fail_mask
);
   localparam int M = 2**N_IN;
   state_t            r_state;
   logic [N_IN-1:0]   r_m;
   logic [N_IN-1:0]   r_x;
   logic              r_busy;
   logic              r_done;
   logic              r_pass;
   logic [N_IN:0]     r_err;
   logic [M-1:0]      r_mask;
   logic              w_mismatch;
   logic              w_last;
   assign w_last = r_m == N_IN'(M-1);
   tt_compare #(.N_IN(N_IN)) u_cmp (
      .i_m        (r_m),
      .i_truth    (TRUTH),
      .i_dut_s    (dut_s),
      .o_mismatch (w_mismatch)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_m     <= '0;
         r_x     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_err   <= '0;
         r_mask  <= '0;
      end else begin
         case (r_state)
            IDLE: if (start) begin
               r_state <= APPLY;
               r_m     <= '0;
               r_x     <= '0;
               r_busy  <= 1'b1;
               r_pass  <= 1'b0;
               r_err   <= '0;
               r_mask  <= '0;
            end
            APPLY: r_state <= CHECK;
            CHECK: begin
               if (w_mismatch) begin
                  r_err         <= r_err + 1'b1;
                  r_mask[r_m]   <= 1'b1;
               end
               if (w_last) begin
                  r_state <= DONE;
                  r_x     <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (r_err == '0) && !w_mismatch;
               end else begin
                  r_state <= APPLY;
                  r_m     <= r_m + 1'b1;
                  r_x     <= r_m + 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign x         = r_x;
   assign busy      = r_busy;
   assign done      = r_done;
   assign pass      = r_pass;
   assign err_count = r_err;
   assign fail_mask = r_mask;
endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: scoreboarded random and directed sweeps of the sequencer against a table model
module tb_truth_table_sequencer;
   import tt_pkg::*;
   typedef struct {
      logic [2:0] err;
      logic [3:0] mask;
      logic       pass;
   } res_t;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] gate_tt = TT_NAND2;
   logic       dut_s;
   logic [1:0] x;
   logic       busy, done, pass;
   logic [2:0] err_count;
   logic [3:0] fail_mask;
   int         tests = 0, fails = 0, done_cnt = 0, exp_dones = 0;
   res_t       q[$];
   res_t       mon_e;
   truth_table_sequencer #(.N_IN(2), .TRUTH(TT_NAND2)) dut (
      .clk(clk), .rst(rst), .start(start), .dut_s(dut_s), .x(x), .busy(busy),
      .done(done), .pass(pass), .err_count(err_count), .fail_mask(fail_mask)
   );
   always #5 clk = ~clk;
   // the gate under test is any 2-input function, given as its own output table
   assign dut_s = gate_tt[x];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask
   function automatic res_t model(input logic [3:0] tt);
      res_t r;
      r.mask = tt ^ TT_NAND2;
      r.err  = 3'($countones(r.mask));
      r.pass = r.mask == 4'b0;
      return r;
   endfunction
   task automatic expect_sweep(input logic [3:0] tt);
      q.push_back(model(tt));
      exp_dones++;
   endtask
   always @(negedge clk) begin
      if (done) begin
         done_cnt++;
         if (q.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            mon_e = q.pop_front();
            chk("err_count", err_count, mon_e.err);
            chk("fail_mask", fail_mask, mon_e.mask);
            chk("pass", pass, mon_e.pass);
         end
      end
   end
   task automatic sweep(input logic [3:0] tt, input bit repulse);
      gate_tt = tt;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      expect_sweep(tt);
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         if (j == 0) start = 1'b0;
         if (repulse && j == 3) start = 1'b1;
         if (repulse && j == 4) start = 1'b0;
         chk("x_seq", x, j < 8 ? j / 2 : 0);
         chk("busy_seq", busy, j < 8);
         chk("done_time", done, j == 8);
      end
   endtask
   task automatic rst_mid();
      gate_tt = TT_AND2;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         if (j == 0) start = 1'b0;
      end
      chk("err_before_rst", err_count, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_x", x, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_count, 0);
      chk("rst_mask", fail_mask, 0);
      chk("rst_pass", pass, 0);
      chk("rst_done", done, 0);
      repeat (12) @(negedge clk);
      chk("rst_idle_busy", busy, 0);
   endtask
   task automatic held_start(input logic [3:0] tt);
      gate_tt = tt;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (k % 10 == 0) expect_sweep(tt);
         if (k == 29) start = 1'b0;
         chk("held_busy", busy, (k % 10) < 8);
         chk("held_done", done, (k % 10) == 8);
      end
   endtask
   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_x", x, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_pass", pass, 0);
      chk("reset_err", err_count, 0);
      chk("reset_mask", fail_mask, 0);
      rst = 1'b0;
      sweep(TT_NAND2, 1'b0);
      sweep(TT_AND2, 1'b0);
      sweep(4'b1111, 1'b0);
      sweep(TT_NAND2, 1'b0);
      sweep(TT_XOR2, 1'b1);
      rst_mid();
      held_start(TT_OR2);
      repeat (12) sweep(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      repeat (2) @(negedge clk);
      chk("done_count", done_cnt, exp_dones);
      chk("queue_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
